// File: rtl/alu_pkg.sv
// Shared ALU control encodings, FSM states and helpers.
// Used by the control-unit decoder and the execute-side ALUs.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_state_e;

    function automatic logic is_shift(alu_ctrl_e c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU core: add/sub/compare/logic plus illegal-code detect.
// Shift codes are legal here but produce zero; shifting lives elsewhere.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_ctrl_e'(ctrl))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/iterative_alu.sv
// Handshaked ALU with one-bit-per-cycle shifts.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       alu_control_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    alu_state_e         state, state_n;
    alu_ctrl_e          op;
    logic [WIDTH-1:0]   core_res;
    logic [WIDTH-1:0]   op_res;
    logic               core_ill;
    logic               accept;
    logic               long_op;
    logic [SHAMT_W-1:0] shamt;

    assign op      = alu_ctrl_e'(alu_control_i);
    assign shamt   = b_i[SHAMT_W-1:0];
    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign accept  = valid_i & ready_o & ~flush_i;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .ctrl    (alu_control_i),
        .a       (a_i),
        .b       (b_i),
        .result  (core_res),
        .illegal (core_ill)
    );

`ifdef ALU_FAST_SHIFT_EN
    always_comb begin
        op_res = core_res;
        case (op)
            ALU_SLL: op_res = a_i << shamt;
            ALU_SRL: op_res = a_i >> shamt;
            ALU_SRA: op_res = $signed(a_i) >>> shamt;
            default: op_res = core_res;
        endcase
    end

    assign long_op = 1'b0;
`else
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_step;
    logic [SHAMT_W-1:0] cnt;
    logic               shift_left;
    logic               shift_arith;

    // A zero-distance shift is just a pass-through of operand A.
    assign op_res  = is_shift(op) ? a_i : core_res;
    assign long_op = is_shift(op) && (shamt != '0);

    assign acc_step = shift_left
        ? {acc[WIDTH-2:0], 1'b0}
        : {shift_arith & acc[WIDTH-1], acc[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc         <= '0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (accept && long_op) begin
            acc         <= a_i;
            cnt         <= shamt;
            shift_left  <= (op == ALU_SLL);
            shift_arith <= (op == ALU_SRA);
        end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = long_op ? SHIFT : DONE;
`ifdef ALU_FAST_SHIFT_EN
            SHIFT: state_n = IDLE;
`else
            SHIFT: if (cnt == SHAMT_W'(1)) state_n = DONE;
`endif
            DONE: if (ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // Flush leaves the last result visible; only valid_o drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o  <= '0;
            zero_o    <= 1'b1;
            illegal_o <= 1'b0;
        end else if (!flush_i) begin
            if (accept && !long_op) begin
                result_o  <= op_res;
                zero_o    <= (op_res == '0);
                illegal_o <= core_ill;
            end
`ifndef ALU_FAST_SHIFT_EN
            else if (state == SHIFT && cnt == SHAMT_W'(1)) begin
                result_o  <= acc_step;
                zero_o    <= (acc_step == '0);
                illegal_o <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed-vector bench for iterative_alu.
// Shift latency expectations follow ALU_FAST_SHIFT_EN.
module tb_iterative_alu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_control_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;
    int lat;

    iterative_alu #(.WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .alu_control_i (alu_control_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int shift_lat(input int k);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        return k;
`endif
    endfunction

    // Drive one request for exactly one accepting edge, then scramble operands.
    task automatic issue(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk_i);
        valid_i       = 1'b1;
        alu_control_i = code;
        a_i           = a;
        b_i           = b;
        @(posedge clk_i);
        #1;
        valid_i       = 1'b0;
        alu_control_i = 4'b1111;
        a_i           = 32'hDEAD_BEEF;
        b_i           = 32'hFFFF_FFFF;
    endtask

    // Edges after the accept edge until valid_o; -1 when the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 64) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!valid_o) n = -1;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ready_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        checks++;
        if (result_o !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h want 0", result_o);
        end
        checks++;
        if (zero_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got z=%b i=%b want z=1 i=0",
                     zero_o, illegal_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_sub();
        issue(4'b1000, 32'd5, 32'd5);
        wait_valid(lat);
        checks++;
        if (lat !== 0) begin
            errors++; $display("FAIL sub_latency: got %0d want 0", lat);
        end
        checks++;
        if (result_o !== 32'h0 || zero_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL sub_result: got %h z=%b i=%b want 0 z=1 i=0",
                     result_o, zero_o, illegal_o);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL sub_busy: got ready %b want 0", ready_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL sub_return_idle: got r=%b v=%b want r=1 v=0",
                     ready_o, valid_o);
        end
    endtask

    task automatic test_compare();
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'd1) begin
            errors++; $display("FAIL slt: got %h lat %0d want 1 lat 0", result_o, lat);
        end
        drain();
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'd0) begin
            errors++; $display("FAIL sltu: got %h lat %0d want 0 lat 0", result_o, lat);
        end
        drain();
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat);
        checks++;
        if (result_o !== 32'd0 || zero_o !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: got %h z=%b want 0 z=1", result_o, zero_o);
        end
        drain();
    endtask

    task automatic test_shift();
        issue(4'b1101, 32'h8000_0000, 32'h24);
        wait_valid(lat);
        checks++;
        if (lat !== shift_lat(4)) begin
            errors++; $display("FAIL sra_latency: got %0d want %0d", lat, shift_lat(4));
        end
        checks++;
        if (result_o !== 32'hF800_0000 || zero_o !== 1'b0) begin
            errors++; $display("FAIL sra_result: got %h want f8000000", result_o);
        end
        drain();
        issue(4'b0101, 32'h8000_0000, 32'h24);
        wait_valid(lat);
        checks++;
        if (lat !== shift_lat(4) || result_o !== 32'h0800_0000) begin
            errors++;
            $display("FAIL srl: got %h lat %0d want 08000000 lat %0d",
                     result_o, lat, shift_lat(4));
        end
        drain();
        issue(4'b0001, 32'h0000_0001, 32'h20);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'h1) begin
            errors++; $display("FAIL sll_zero: got %h lat %0d want 1 lat 0", result_o, lat);
        end
        drain();
        issue(4'b0001, 32'h0000_0003, 32'h3);
        wait_valid(lat);
        checks++;
        if (lat !== shift_lat(3) || result_o !== 32'h18) begin
            errors++; $display("FAIL sll3: got %h lat %0d want 18", result_o, lat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        issue(4'b0111, 32'h0000_F0F0, 32'h0000_FF00);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'h0000_F000) begin
            errors++; $display("FAIL and_result: got %h want 0000f000", result_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h0000_F000) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b r=%b %h want v=1 r=0 0000f000",
                         i, valid_o, ready_o, result_o);
            end
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL release: got r=%b v=%b want r=1 v=0", ready_o, valid_o);
        end
    endtask

    task automatic test_illegal();
        issue(4'b1111, 32'h1234_5678, 32'h1);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'h0 || illegal_o !== 1'b1 || zero_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal: got %h i=%b z=%b lat %0d want 0 i=1 z=1",
                     result_o, illegal_o, zero_o, lat);
        end
        drain();
    endtask

    task automatic test_flush();
        int seen;
        issue(4'b0001, 32'h1, 32'd20);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got r=%b v=%b want r=1 v=0", ready_o, valid_o);
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL flush_novalid: got %0d valid cycles want 0", seen);
        end
        checks++;
        if (result_o !== 32'h0 || illegal_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_retain: got %h i=%b want 0 i=1", result_o, illegal_o);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(4'b1101, 32'h8000_0000, 32'd20);
        repeat (3) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0 ||
            zero_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got r=%b v=%b %h z=%b i=%b",
                     ready_o, valid_o, result_o, zero_o, illegal_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        issue(4'b0100, 32'hA5, 32'hFF);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || result_o !== 32'h5A || zero_o !== 1'b0) begin
            errors++; $display("FAIL xor_after_reset: got %h lat %0d want 5a", result_o, lat);
        end
        drain();
    endtask

    initial begin
        valid_i       = 1'b0;
        alu_control_i = 4'b0000;
        a_i           = '0;
        b_i           = '0;
        flush_i       = 1'b0;
        ready_i       = 1'b1;
        test_reset();
        test_sub();
        test_compare();
        test_shift();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
